// File: rtl/count_arb.sv
// count_arb: two-requester arbiter driving a shared up-counter.
//
// A granted requester gets the counter for one run. The counter counts from 0
// up to the length that requester presented at grant time. The requester then
// gets a one-cycle done pulse, and the arbiter releases the grant.
//
// Ports
//   clk    - clock; all state changes on its rising edge
//   reset  - synchronous, active-low reset
//   req    - per-requester level request (bit i = requester i)
//   len0   - terminal count for requester 0, sampled at grant
//   len1   - terminal count for requester 1, sampled at grant
//   gnt    - one-hot grant, registered
//   busy   - high while a grant is active (RUN or DONE), registered
//   out    - shared counter value, registered
//   done   - one-cycle completion pulse to the granted requester, registered
//
// Configuration
//   COUNT_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie
//                             and no round-robin pointer is built. When
//                             undefined, a round-robin pointer breaks ties.

module count_arb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] term;
    logic             owner;
    logic             favoured;
    logic             pick;

`ifdef COUNT_ARB_FIXED_PRIO_EN
    assign favoured = 1'b0;
`else
    logic             ptr;
    assign favoured = ptr;
`endif

    // The favoured requester only matters when both requesters ask at once.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = favoured;
            default: pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            done  <= 2'b00;
            out   <= '0;
            term  <= '0;
            owner <= 1'b0;
`ifndef COUNT_ARB_FIXED_PRIO_EN
            ptr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (req != 2'b00) begin
                        owner <= pick;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        term  <= pick ? len1 : len0;
                        out   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        gnt  <= 2'b00;
                        busy <= 1'b0;
                    end
                end

                // Losing the request takes priority over counting or
                // finishing, so an abort never produces a done pulse.
                RUN: begin
                    if (!req[owner]) begin
                        gnt   <= 2'b00;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifndef COUNT_ARB_FIXED_PRIO_EN
                        ptr   <= ~owner;
`endif
                    end else if (out == term) begin
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        out <= out + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end

                DONE: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    done  <= 2'b00;
                    state <= IDLE;
`ifndef COUNT_ARB_FIXED_PRIO_EN
                    ptr   <= ~owner;
`endif
                end

                default: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    done  <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_arb.sv
// tb_count_arb: self-checking bench for count_arb.
// Runs directed scenarios, then a randomized run. Every cycle it compares
// all outputs against a run-level reference model.

module tb_count_arb;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] out;
    logic [1:0]       done;

    int checkCount;
    int errorCount;

    // Reference model: a run is "active" for term+2 cycles after the grant.
    // elapsed = 0..term are counting cycles; elapsed = term+1 is the done cycle.
    int mActive;
    int mOwner;
    int mTerm;
    int mElapsed;
    int mOut;
    int mFavour;

    count_arb #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .out   (out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic modelStep();
        int winner;
        if (!reset) begin
            mActive  = 0;
            mOwner   = 0;
            mTerm    = 0;
            mElapsed = 0;
            mOut     = 0;
            mFavour  = 0;
        end else if (mActive != 0) begin
            if (mElapsed == mTerm + 1) begin
                mActive = 0;
                mFavour = 1 - mOwner;
            end else if (req[mOwner] == 1'b0) begin
                mActive = 0;
                mFavour = 1 - mOwner;
            end else begin
                mElapsed++;
                mOut = (mElapsed > mTerm) ? mTerm : mElapsed;
            end
        end else if (req != 2'b00) begin
`ifdef COUNT_ARB_FIXED_PRIO_EN
            winner = req[0] ? 0 : 1;
`else
            if (req == 2'b11) winner = mFavour;
            else              winner = req[0] ? 0 : 1;
`endif
            mActive  = 1;
            mOwner   = winner;
            mTerm    = (winner == 0) ? int'(len0) : int'(len1);
            mElapsed = 0;
            mOut     = 0;
        end
    endtask

    // Apply inputs, clock one edge, update the model and check all outputs.
    task automatic applyStimulus(input logic rst, input logic [1:0] q, input int l0, input int l1);
        int expGnt;
        int expDone;
        reset = rst;
        req   = q;
        len0  = WIDTH'(l0);
        len1  = WIDTH'(l1);
        @(posedge clk);
        modelStep();
        #1;
        expGnt  = (mActive != 0) ? (1 << mOwner) : 0;
        expDone = (mActive != 0 && mElapsed == mTerm + 1) ? (1 << mOwner) : 0;
        checkOutput("gnt",  int'(gnt),  expGnt);
        checkOutput("busy", int'(busy), (mActive != 0) ? 1 : 0);
        checkOutput("out",  int'(out),  mOut);
        checkOutput("done", int'(done), expDone);
        checkOutput("onehot", int'($countones(gnt) <= 1 && $countones(done) <= 1), 1);
    endtask

    task automatic repeatStimulus(input int n, input logic rst, input logic [1:0] q, input int l0, input int l1);
        for (int i = 0; i < n; i++) applyStimulus(rst, q, l0, l1);
    endtask

    initial begin
        logic       rr;
        logic [1:0] q;
        checkCount = 0;
        errorCount = 0;
        mActive = 0; mOwner = 0; mTerm = 0; mElapsed = 0; mOut = 0; mFavour = 0;
        reset = 1'b0; req = 2'b00; len0 = '0; len1 = '0;

        $display("[TB] reset and idle");
        repeatStimulus(2, 1'b0, 2'b00, 0, 0);
        repeatStimulus(3, 1'b1, 2'b00, 0, 0);

        $display("[TB] single run, len0=3");
        repeatStimulus(6, 1'b1, 2'b01, 3, 0);
        repeatStimulus(2, 1'b1, 2'b00, 0, 0);

        $display("[TB] contention, len0=2 len1=1");
        repeatStimulus(20, 1'b1, 2'b11, 2, 1);
        repeatStimulus(2, 1'b1, 2'b00, 0, 0);

        $display("[TB] boundary lengths on requester 1");
        repeatStimulus(4, 1'b1, 2'b10, 0, 0);
        repeatStimulus(2, 1'b1, 2'b00, 0, 0);
        applyStimulus(1'b1, 2'b10, 0, 15);
        repeatStimulus(18, 1'b1, 2'b10, 0, 3);
        repeatStimulus(2, 1'b1, 2'b00, 0, 0);

        $display("[TB] abort by request drop");
        repeatStimulus(5, 1'b1, 2'b01, 9, 0);
        checkOutput("abort_pre_out", int'(out), 4);
        applyStimulus(1'b1, 2'b00, 9, 0);
        checkOutput("abort_out", int'(out), 4);
        checkOutput("abort_gnt", int'(gnt), 0);
        applyStimulus(1'b1, 2'b11, 1, 1);
`ifdef COUNT_ARB_FIXED_PRIO_EN
        checkOutput("after_abort_gnt", int'(gnt), 1);
`else
        checkOutput("after_abort_gnt", int'(gnt), 2);
`endif
        repeatStimulus(5, 1'b1, 2'b00, 0, 0);

        $display("[TB] reset mid-run");
        repeatStimulus(6, 1'b1, 2'b01, 7, 0);
        checkOutput("pre_reset_out", int'(out), 5);
        applyStimulus(1'b0, 2'b01, 7, 0);
        checkOutput("reset_out", int'(out), 0);
        applyStimulus(1'b1, 2'b11, 1, 1);
        checkOutput("post_reset_gnt", int'(gnt), 1);
        repeatStimulus(5, 1'b1, 2'b00, 0, 0);

        $display("[TB] randomized run");
        q = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) q = 2'($urandom_range(3));
            rr = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
            applyStimulus(rr, q, int'($urandom_range(15)), int'($urandom_range(15)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/count_arb.md
COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the shared counter and of each length input.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  2  per-requester run request, level; bit i belongs to requester i.
REQ-005 len0  input  WIDTH  terminal count requested by requester 0; sampled only at grant.
REQ-006 len1  input  WIDTH  terminal count requested by requester 1; sampled only at grant.
REQ-007 gnt  output  2  one-hot grant; at most one bit set at any time.
REQ-008 busy  output  1  high while any grant is active (RUN or DONE state).
REQ-009 out  output  WIDTH  shared counter value.
REQ-010 done  output  2  one-cycle completion pulse to the granted requester.

Function
REQ-011 The block SHALL implement three registered states: IDLE, RUN, DONE; all outputs are registered.
REQ-012 In IDLE with req != 0, the block SHALL on the next edge set gnt to the selected requester, capture that requester's len into an internal terminal register, set out=0, enter RUN.
REQ-013 In IDLE with req == 0, the block SHALL hold gnt=0, out at its last value, busy=0.
REQ-014 Selection SHALL be round-robin: a pointer names the favoured requester; when only one requests it wins; when both request the pointer's requester wins.
REQ-015 In RUN, out SHALL increment by 1 each cycle while out != terminal; when out == terminal the block SHALL enter DONE on the next edge with out held.
REQ-016 A captured terminal of 0 SHALL give exactly one RUN cycle (out=0) before DONE; terminal 2^WIDTH-1 SHALL give 2^WIDTH RUN cycles with no wrap-around.
REQ-017 In DONE, done[i] SHALL be 1 for exactly that cycle for the granted i, gnt held; next edge returns to IDLE, gnt=0, pointer set to the other requester.
REQ-018 If the granted requester's req drops during RUN, the block SHALL abort: next edge to IDLE, gnt=0, no done pulse, out held, pointer set to the other requester.
REQ-019 Changes to len0/len1 after grant SHALL have no effect on the current run.
REQ-020 Request transitions of the non-granted requester during RUN/DONE SHALL be ignored until IDLE.
REQ-021 Minimum grant-to-grant gap SHALL be one IDLE cycle; req seen in IDLE at edge N gives gnt at edge N+1.
REQ-022 gnt, busy and done SHALL never have more than one bit of gnt or done set.

Reset
REQ-023 With reset=0 at a clk edge, the block SHALL enter IDLE with gnt=0, busy=0, done=0, out=0, terminal=0, pointer=requester 0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort immediately with no done pulse.

Configuration
REQ-025 Macro COUNT_ARB_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (requester 0 always wins when both request) and the pointer is not implemented; when undefined, round-robin per REQ-014.

Verification
REQ-026 Reset low 2 cycles, then high, req=00 -> gnt=00, busy=0, out=0, done=00 every cycle.
REQ-027 req=01, len0=3 -> gnt=01 one edge later, out 0,1,2,3 over 4 RUN cycles, then done=01 for 1 cycle, then gnt=00.
REQ-028 req=11 held, len0=2, len1=1 -> grants alternate 01,10,01 (round-robin); with COUNT_ARB_FIXED_PRIO_EN grants stay 01.
REQ-029 req=10, len1=0 -> one RUN cycle out=0, then done=10; len1=15 -> out 0..15, no wrap, then done=10.
REQ-030 req=01, len0=9, drop req at out=4 -> next edge gnt=00, done=00, out=4; following req=11 grants requester 1.
REQ-031 req=01, len0=7, reset low at out=5 -> next edge gnt=00, out=0, done=00, pointer=requester 0.
